// File: rtl/ws2812_matrix_scanner_pkg.sv
// Shared definitions for the WS2812 matrix scanner: controller command codes
// (the same codes ws2812_rgb_controller decodes) and scanner state encodings.
package ws2812_matrix_scanner_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_START      = 3'd2;
  localparam logic [2:0] ST_ADVANCE    = 3'd3;
  localparam logic [2:0] ST_LOAD       = 3'd4;
  localparam logic [2:0] ST_WAIT_DATA  = 3'd5;
  localparam logic [2:0] ST_LATCH      = 3'd6;
  localparam logic [2:0] ST_WAIT_LATCH = 3'd7;

  // Command presented to the controller in each scanner state.
  function automatic logic [1:0] state_cmd(input logic [2:0] st);
    case (st)
      ST_START, ST_ADVANCE, ST_LOAD, ST_WAIT_DATA: state_cmd = CMD_TX;
      ST_LATCH, ST_WAIT_LATCH:                     state_cmd = CMD_RESET;
      default:                                     state_cmd = CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ws2812_matrix_addr_gen.sv
// Raster row/column counters for the matrix scanner. Produces the framebuffer
// read address (with optional serpentine column mirroring on odd rows) and a
// flag marking the last pixel of the frame. Stepping past the last pixel wraps
// back to (0,0).
module ws2812_matrix_addr_gen #(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 1,
  parameter int SERPENTINE = 0,
  parameter int COORD_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] fb_row,
  output logic [COORD_W-1:0] fb_column,
  output logic               last
);

  // One bit wider than the address so WIDTH/HEIGHT = 2**COORD_W compare correctly.
  localparam logic [COORD_W:0]   WIDTH_EXT  = (COORD_W+1)'(WIDTH);
  localparam logic [COORD_W:0]   HEIGHT_EXT = (COORD_W+1)'(HEIGHT);
  localparam logic [COORD_W:0]   ONE_EXT    = (COORD_W+1)'(1);
  localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);
  localparam logic [COORD_W-1:0] COL_MAX    = COORD_W'(WIDTH - 1);

  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               col_end;
  logic               row_end;

  assign col_end = ({1'b0, col} + ONE_EXT) >= WIDTH_EXT;
  assign row_end = ({1'b0, row} + ONE_EXT) >= HEIGHT_EXT;
  assign last    = col_end && row_end;

  assign fb_row    = row;
  assign fb_column = ((SERPENTINE != 0) && row[0]) ? (COL_MAX - col) : col;

  // Raster counters: column first, row on column wrap, both wrap after the last pixel.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (!col_end) begin
        col <= col + ONE;
      end else begin
        col <= '0;
        row <= row_end ? '0 : row + ONE;
      end
    end
  end

endmodule

// File: rtl/ws2812_matrix_scanner.sv
// Frame refresh sequencer: walks the framebuffer in raster order, latches each
// pixel colour and hands it to the WS2812 controller through the TX/RESET
// command handshake, closing every frame with a RESET latch command.
module ws2812_matrix_scanner
  import ws2812_matrix_scanner_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 1,
  parameter int SERPENTINE = 0,
  parameter int COORD_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [COORD_W-1:0] fb_row,
  output logic [COORD_W-1:0] fb_column,
  input  logic [7:0]         fb_r,
  input  logic [7:0]         fb_g,
  input  logic [7:0]         fb_b,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic [1:0]         cmd,
  input  logic               cmd_req,
  input  logic               data_req,
  output logic               busy,
  output logic               frame_done
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       last;
  logic       addr_step;
  logic       addr_clear;

  // Counters step only in ADVANCE; IDLE holds them at (0,0) for the next frame.
  assign addr_step  = (state == ST_ADVANCE);
  assign addr_clear = (state == ST_IDLE);
  assign cmd        = state_cmd(state);

  ws2812_matrix_addr_gen #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .SERPENTINE (SERPENTINE),
    .COORD_W    (COORD_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (addr_clear),
    .step      (addr_step),
    .fb_row    (fb_row),
    .fb_column (fb_column),
    .last      (last)
  );

  // Next-state logic; each wait state reacts only to the strobe it waits for.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:       if (enable) state_nxt = ST_FETCH;
      ST_FETCH:      state_nxt = ST_START;
      ST_START:      if (cmd_req) state_nxt = ST_ADVANCE;
      ST_ADVANCE:    state_nxt = last ? ST_LATCH : ST_LOAD;
      ST_LOAD:       state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA:  if (data_req) state_nxt = ST_ADVANCE;
      ST_LATCH:      if (cmd_req) state_nxt = ST_WAIT_LATCH;
      ST_WAIT_LATCH: if (cmd_req) state_nxt = enable ? ST_FETCH : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // State, status flags and colour registers; colour changes only in FETCH/LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state == ST_WAIT_LATCH) && cmd_req;
      if ((state == ST_FETCH) || (state == ST_LOAD)) begin
        r <= fb_r;
        g <= fb_g;
        b <= fb_b;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_matrix_scanner.sv
// Bench for ws2812_matrix_scanner. A 4x1 instance is driven cycle by cycle from
// a table of vectors; three more instances (3x2 serpentine, 1x1, 256x1) run two
// frames each against a small controller model, the second with enable dropped.
module tb_ws2812_matrix_scanner;
  import ws2812_matrix_scanner_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Framebuffer contents for the model-driven instances.
  function automatic logic [23:0] mem_model(input int cfg, input logic [7:0] row, input logic [7:0] col);
    if (cfg == 1) return (row == 8'd0 && col == 8'd0) ? 24'h123456 : 24'h000000;
    return {row, col, 8'h5A};
  endfunction

  // ---------------- table-driven 4x1 instance ----------------
  logic       rst, enable, cmd_req, data_req;
  logic [7:0] fb_row, fb_column, fb_r, fb_g, fb_b, d_r, d_g, d_b;
  logic [1:0] cmd;
  logic       busy, frame_done;

  localparam logic [23:0] P0 = 24'hFF0000;
  localparam logic [23:0] P1 = 24'h00FF00;
  localparam logic [23:0] P2 = 24'h0000FF;
  localparam logic [23:0] P3 = 24'hFFFFFF;

  always_comb begin
    case (fb_column)
      8'd0:    {fb_r, fb_g, fb_b} = P0;
      8'd1:    {fb_r, fb_g, fb_b} = P1;
      8'd2:    {fb_r, fb_g, fb_b} = P2;
      8'd3:    {fb_r, fb_g, fb_b} = P3;
      default: {fb_r, fb_g, fb_b} = 24'h000000;
    endcase
  end

  ws2812_matrix_scanner #(.WIDTH(4), .HEIGHT(1), .SERPENTINE(0), .COORD_W(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_row(fb_row), .fb_column(fb_column),
    .fb_r(fb_r), .fb_g(fb_g), .fb_b(fb_b),
    .r(d_r), .g(d_g), .b(d_b),
    .cmd(cmd), .cmd_req(cmd_req), .data_req(data_req),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic        rst, en, creq, dreq;
    logic [1:0]  cmd;
    logic        busy, fd;
    logic [7:0]  col;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_i, input logic en, input logic creq, input logic dreq,
                              input logic [1:0] c, input logic bsy, input logic fd,
                              input logic [7:0] col, input logic [23:0] rgb);
    vec_t v;
    v.rst = rst_i; v.en = en; v.creq = creq; v.dreq = dreq;
    v.cmd = c; v.busy = bsy; v.fd = fd; v.col = col; v.rgb = rgb;
    return v;
  endfunction

  // ---------------- model-driven instances ----------------
  logic rst_a;

  for (genvar gi = 0; gi < 3; gi++) begin : gc
    localparam int W = (gi == 0) ? 3 : (gi == 1) ? 1 : 256;
    localparam int H = (gi == 0) ? 2 : 1;
    localparam int S = (gi == 0) ? 1 : 0;

    logic       en, creq, dreq, busy_i, fd, done;
    logic [7:0] row, col, pr, pg, pb, mr, mg, mb;
    logic [1:0] cmd_i;
    int         nfd;

    assign {mr, mg, mb} = mem_model(gi, row, col);

    ws2812_matrix_scanner #(.WIDTH(W), .HEIGHT(H), .SERPENTINE(S), .COORD_W(8)) u (
      .clk(clk), .rst(rst_a), .enable(en),
      .fb_row(row), .fb_column(col),
      .fb_r(mr), .fb_g(mg), .fb_b(mb),
      .r(pr), .g(pg), .b(pb),
      .cmd(cmd_i), .cmd_req(creq), .data_req(dreq),
      .busy(busy_i), .frame_done(fd)
    );

    always @(posedge clk) begin
      if (rst_a) nfd <= 0;
      else if (fd) nfd <= nfd + 1;
    end

    // Controller model: takes pixel 0 with cmd_req, the rest with data_req,
    // then acknowledges and completes the RESET latch.
    initial begin : ctl
      en = 1'b0; creq = 1'b0; dreq = 1'b0; done = 1'b0;
      wait (!rst_a);
      @(negedge clk);
      en = 1'b1;
      for (int f = 0; f < 2; f++) begin
        int k, cnt, lrow, lcol, ecol;
        logic ended;
        k = 0;
        while (cmd_i !== CMD_TX && k < 40) begin
          @(negedge clk);
          k++;
        end
        check($sformatf("cfg%0d_f%0d_tx_wait", gi, f), cmd_i, CMD_TX);
        cnt = 0;
        ended = 1'b0;
        while (!ended && cnt < W * H + 2) begin
          if (cnt > 0) begin
            repeat (3) @(negedge clk);
          end
          if (cnt > 0 && cmd_i === CMD_RESET) begin
            ended = 1'b1;
          end else begin
            lrow = cnt / W;
            lcol = cnt % W;
            ecol = (S != 0 && (lrow % 2) == 1) ? (W - 1 - lcol) : lcol;
            check($sformatf("cfg%0d_f%0d_px%0d", gi, f, cnt),
                  {cmd_i, row, col, pr, pg, pb},
                  {CMD_TX, 8'(lrow), 8'(ecol), mem_model(gi, 8'(lrow), 8'(ecol))});
            if (cnt == 0) creq = 1'b1;
            else          dreq = 1'b1;
            @(negedge clk);
            creq = 1'b0;
            dreq = 1'b0;
            if (f == 1) en = 1'b0;
            cnt++;
          end
        end
        check($sformatf("cfg%0d_f%0d_pixel_count", gi, f), cnt, W * H);
        check($sformatf("cfg%0d_f%0d_latch_cmd", gi, f), cmd_i, CMD_RESET);
        creq = 1'b1;
        @(negedge clk);
        creq = 1'b0;
        repeat (2) @(negedge clk);
        check($sformatf("cfg%0d_f%0d_latch_hold", gi, f), {cmd_i, fd}, {CMD_RESET, 1'b0});
        creq = 1'b1;
        @(negedge clk);
        creq = 1'b0;
        check($sformatf("cfg%0d_f%0d_done", gi, f), {fd, cmd_i, busy_i}, {1'b1, CMD_IDLE, (f == 0)});
      end
      repeat (12) @(negedge clk);
      check($sformatf("cfg%0d_stays_idle", gi), {cmd_i, busy_i}, {CMD_IDLE, 1'b0});
      check($sformatf("cfg%0d_frame_done_count", gi), nfd, 2);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    logic all_done;
    rst = 1'b1; enable = 1'b0; cmd_req = 1'b0; data_req = 1'b0;
    rst_a = 1'b1;

    //                 rst   en    creq  dreq  cmd        busy  fd    col  rgb
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, CMD_IDLE,  1'b0, 1'b0, 8'd0, 24'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_IDLE,  1'b1, 1'b0, 8'd0, 24'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd1, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd1, P1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd1, P1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd2, P1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd2, P2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd2, P2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd3, P2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd3, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd3, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_RESET, 1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, CMD_RESET, 1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, CMD_RESET, 1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_RESET, 1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, CMD_IDLE,  1'b1, 1'b1, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    // enable dropped as pixel 0 is taken: the whole frame and latch still run
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd1, P0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd1, P1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd1, P1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd2, P1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd2, P2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd2, P2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd3, P2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd3, P3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, CMD_TX,    1'b1, 1'b0, 8'd3, P3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_RESET, 1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, CMD_RESET, 1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, CMD_IDLE,  1'b0, 1'b1, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, CMD_IDLE,  1'b0, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, CMD_IDLE,  1'b0, 1'b0, 8'd0, P3));
    // restart, then synchronous reset while waiting for data_req on pixel 1
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_IDLE,  1'b1, 1'b0, 8'd0, P3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd1, P0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd1, P1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, CMD_IDLE,  1'b0, 1'b0, 8'd0, 24'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_IDLE,  1'b1, 1'b0, 8'd0, 24'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, CMD_TX,    1'b1, 1'b0, 8'd0, P0));

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      enable   = vecs[i].en;
      cmd_req  = vecs[i].creq;
      data_req = vecs[i].dreq;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cmd", i), cmd, vecs[i].cmd);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].fd);
      check($sformatf("vec%0d_addr", i), {fb_row, fb_column}, {8'd0, vecs[i].col});
      check($sformatf("vec%0d_rgb", i), {d_r, d_g, d_b}, vecs[i].rgb);
    end
    cmd_req  = 1'b0;
    data_req = 1'b0;

    k = 0;
    all_done = 1'b0;
    while (!all_done && k < 20000) begin
      @(negedge clk);
      all_done = gc[0].done && gc[1].done && gc[2].done;
      k++;
    end
    check("model_instances_finished", all_done, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
